// File: rtl/stuff_data_mux.sv
// Stuff/data output multiplexer.
// Buffers payload words in a small FIFO and, for every slot announced by the
// upstream decision stage, emits either the next payload word (data slot) or
// STUFF_WORD (stuff slot). It also marks frame starts, reports underflow and
// slots seen before any sof, and counts the data words in each frame.
module stuff_data_mux #(
  parameter int                MPT_W      = 8,
  parameter int                DATA_W     = 8,
  parameter int                FIFO_DEPTH = 16,
  parameter logic [DATA_W-1:0] STUFF_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sof_in,
  input  logic              valid_in,
  input  logic              ds,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              dout_sof,
  output logic              dout_is_data,
  output logic              err_underflow,
  output logic              err_nosof,
  output logic [MPT_W-1:0]  frame_data_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              full, empty;
  logic              wr_en, rd_en;

  // Slot decode
  logic slot_take;
  logic slot_uf;
  logic slot_nosof;

  // Output-stage registers
  logic [DATA_W-1:0] dout_p1;
  logic              vld_p1;
  logic              sof_p1;
  logic              is_data_p1;
  logic              uf_p1;
  logic              nosof_p1;
  logic [MPT_W-1:0]  frame_cnt_p1;
  logic [MPT_W-1:0]  run_cnt;

  // Pointers advance modulo the power-of-two depth by natural wrap.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return p + 1'b1;
  endfunction

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign din_ready = ~full;
  assign wr_en     = din_valid & ~full;

  // Next-state and slot decode; sof takes priority over a slot in the same cycle.
  always_comb begin
    state_nxt  = state;
    slot_take  = 1'b0;
    slot_uf    = 1'b0;
    slot_nosof = 1'b0;
    rd_en      = 1'b0;
    if (sof_in) begin
      state_nxt = RUN;
    end
    if (state == IDLE) begin
      slot_nosof = valid_in;
    end else if (valid_in && !sof_in) begin
      slot_take = 1'b1;
      rd_en     = ds & ~empty;
      slot_uf   = ds & empty;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Payload storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  // FIFO pointers and occupancy; a simultaneous read and write leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_en) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (wr_en && !rd_en) begin
        count <= count + 1'b1;
      end else if (rd_en && !wr_en) begin
        count <= count - 1'b1;
      end
    end
  end

  // ---- stage p1: registered slot output, one cycle after the slot strobe ----
  // Output word register; holds its value on cycles without a slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_p1    <= '0;
      is_data_p1 <= 1'b0;
    end else if (slot_take) begin
      dout_p1    <= rd_en ? mem[rd_ptr] : STUFF_WORD;
      is_data_p1 <= rd_en;
    end
  end

  // Strobes and error pulses, each valid for exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      sof_p1   <= 1'b0;
      uf_p1    <= 1'b0;
      nosof_p1 <= 1'b0;
    end else begin
      vld_p1   <= slot_take;
      sof_p1   <= sof_in;
      uf_p1    <= slot_uf;
      nosof_p1 <= slot_nosof;
    end
  end

  // Per-frame data-word counter; latched into the report on each sof while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt      <= '0;
      frame_cnt_p1 <= '0;
    end else if (sof_in) begin
      if (state == RUN) begin
        frame_cnt_p1 <= run_cnt;
      end
      run_cnt <= '0;
    end else if (rd_en) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  assign dout           = dout_p1;
  assign dout_valid     = vld_p1;
  assign dout_sof       = sof_p1;
  assign dout_is_data   = is_data_p1;
  assign err_underflow  = uf_p1;
  assign err_nosof      = nosof_p1;
  assign frame_data_cnt = frame_cnt_p1;

endmodule

// File: tb/tb_stuff_data_mux.sv
// Scoreboard bench for stuff_data_mux: stimulus pushes expected slot words,
// a negedge monitor pops and compares whenever dout_valid is presented.
module tb_stuff_data_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic       sof_in, valid_in, ds, din_valid;
  logic [7:0] din;
  logic       din_ready;
  logic [7:0] dout;
  logic       dout_valid, dout_sof, dout_is_data, err_underflow, err_nosof;
  logic [7:0] frame_data_cnt;

  typedef struct packed {
    logic [7:0] d;
    logic       is_data;
    logic       uf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  stuff_data_mux dut (
    .clk            (clk),
    .rst            (rst),
    .sof_in         (sof_in),
    .valid_in       (valid_in),
    .ds             (ds),
    .din            (din),
    .din_valid      (din_valid),
    .din_ready      (din_ready),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .dout_sof       (dout_sof),
    .dout_is_data   (dout_is_data),
    .err_underflow  (err_underflow),
    .err_nosof      (err_nosof),
    .frame_data_cnt (frame_data_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: actual %0h required %0h", name, act, req);
    else n_pass++;
  endtask

  // Monitor: every presented slot word must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && dout_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_dout_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("dout", {24'd0, dout}, {24'd0, mon_e.d});
        chk("dout_is_data", {31'd0, dout_is_data}, {31'd0, mon_e.is_data});
        chk("err_underflow", {31'd0, err_underflow}, {31'd0, mon_e.uf});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w);
    din       = w;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic slot(input logic d, input logic [7:0] ed, input logic eis, input logic euf);
    exp_q.push_back(exp_t'{ed, eis, euf});
    valid_in = 1'b1;
    ds       = d;
    tick();
    valid_in = 1'b0;
    ds       = 1'b0;
  endtask

  task automatic do_sof(input logic [7:0] exp_cnt);
    sof_in = 1'b1;
    tick();
    sof_in = 1'b0;
    chk("dout_sof", {31'd0, dout_sof}, 32'd1);
    chk("sof_dout_valid", {31'd0, dout_valid}, 32'd0);
    chk("frame_data_cnt", {24'd0, frame_data_cnt}, {24'd0, exp_cnt});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sof_in = 1'b0; valid_in = 1'b0; ds = 1'b0;
    din_valid = 1'b0; din = 8'h00;
    repeat (2) tick();
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_dout_sof", {31'd0, dout_sof}, 32'd0);
    chk("rst_is_data", {31'd0, dout_is_data}, 32'd0);
    chk("rst_err_uf", {31'd0, err_underflow}, 32'd0);
    chk("rst_err_nosof", {31'd0, err_nosof}, 32'd0);
    chk("rst_frame_cnt", {24'd0, frame_data_cnt}, 32'd0);
    chk("rst_din_ready", {31'd0, din_ready}, 32'd1);
    rst = 1'b0;
    tick();

    // Slot before any sof: dropped, error pulse, FIFO contents kept.
    push_word(8'hA1);
    push_word(8'hA2);
    valid_in = 1'b1; ds = 1'b1;
    tick();
    valid_in = 1'b0; ds = 1'b0;
    chk("idle_err_nosof", {31'd0, err_nosof}, 32'd1);
    chk("idle_dout_valid", {31'd0, dout_valid}, 32'd0);
    tick();
    chk("idle_err_nosof_clr", {31'd0, err_nosof}, 32'd0);

    // Basic frame: data, stuff, data.
    do_sof(8'd0);
    tick();
    chk("dout_sof_clr", {31'd0, dout_sof}, 32'd0);
    slot(1'b1, 8'hA1, 1'b1, 1'b0);
    slot(1'b0, 8'h00, 1'b0, 1'b0);
    slot(1'b1, 8'hA2, 1'b1, 1'b0);

    // Underflow on empty FIFO; previous frame carried 2 data words.
    do_sof(8'd2);
    slot(1'b1, 8'h00, 1'b0, 1'b1);
    tick();
    chk("uf_pulse_clr", {31'd0, err_underflow}, 32'd0);

    // Fill to full, drop the 17th word, then reject a write during a read.
    for (int i = 0; i < 16; i++) push_word(8'h10 + 8'(i));
    chk("full_din_ready", {31'd0, din_ready}, 32'd0);
    push_word(8'hEE);
    exp_q.push_back(exp_t'{8'h10, 1'b1, 1'b0});
    din = 8'hEF; din_valid = 1'b1; valid_in = 1'b1; ds = 1'b1;
    tick();
    din_valid = 1'b0; valid_in = 1'b0; ds = 1'b0;
    for (int i = 1; i < 16; i++) slot(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
    slot(1'b1, 8'h00, 1'b0, 1'b1);
    do_sof(8'd16);

    // Frame of 5 data + 3 stuff, then a frame with no data words.
    for (int i = 0; i < 5; i++) push_word(8'h51 + 8'(i));
    slot(1'b1, 8'h51, 1'b1, 1'b0);
    slot(1'b0, 8'h00, 1'b0, 1'b0);
    slot(1'b1, 8'h52, 1'b1, 1'b0);
    slot(1'b0, 8'h00, 1'b0, 1'b0);
    slot(1'b1, 8'h53, 1'b1, 1'b0);
    slot(1'b0, 8'h00, 1'b0, 1'b0);
    slot(1'b1, 8'h54, 1'b1, 1'b0);
    slot(1'b1, 8'h55, 1'b1, 1'b0);
    do_sof(8'd5);
    slot(1'b0, 8'h00, 1'b0, 1'b0);
    slot(1'b1, 8'h00, 1'b0, 1'b1);
    slot(1'b0, 8'h00, 1'b0, 1'b0);
    do_sof(8'd0);

    // Reset mid-frame with a full FIFO and a payload word on dout.
    for (int i = 0; i < 4; i++) push_word(8'h61 + 8'(i));
    slot(1'b1, 8'h61, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) push_word(8'h70 + 8'(i));
    chk("pre_rst_din_ready", {31'd0, din_ready}, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_dout", {24'd0, dout}, 32'd0);
    chk("async_rst_is_data", {31'd0, dout_is_data}, 32'd0);
    chk("async_rst_din_ready", {31'd0, din_ready}, 32'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_din_ready", {31'd0, din_ready}, 32'd1);
    valid_in = 1'b1; ds = 1'b1;
    tick();
    valid_in = 1'b0; ds = 1'b0;
    chk("post_rst_err_nosof", {31'd0, err_nosof}, 32'd1);
    chk("post_rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    do_sof(8'd0);
    slot(1'b1, 8'h00, 1'b0, 1'b1);

    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
